// File: rtl/pwm_bank.sv
// Bus-mapped bank of independent PWM channels with double-buffered duty/period
// and per-channel wrap interrupts.

module pwm_chan #(
    parameter int CtrWidth = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic [CtrWidth-1:0] duty_i,
    input  logic [CtrWidth-1:0] period_i,
    output logic                wrap_o,
    output logic                pwm_o
);
    logic [CtrWidth-1:0] cnt_q, cnt_d;
    logic [CtrWidth-1:0] duty_act_q, duty_act_d;
    logic [CtrWidth-1:0] per_act_q, per_act_d;
    logic                pwm_q, pwm_d;

    assign wrap_o = en_i & (cnt_q == per_act_q);
    assign pwm_o  = pwm_q;

    // Active values only move at a wrap, or continuously while disabled.
    always_comb begin
        cnt_d      = cnt_q;
        duty_act_d = duty_act_q;
        per_act_d  = per_act_q;
        pwm_d      = en_i & (cnt_q < duty_act_q);
        if (!en_i || wrap_o) begin
            cnt_d      = '0;
            duty_act_d = duty_i;
            per_act_d  = period_i;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            duty_act_q <= '0;
            per_act_q  <= '0;
            pwm_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            duty_act_q <= duty_act_d;
            per_act_q  <= per_act_d;
            pwm_q      <= pwm_d;
        end
    end
endmodule

module pwm_bank #(
    parameter int NumChannels = 12,
    parameter int CtrWidth    = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   device_req_i,
    input  logic [31:0]            device_addr_i,
    input  logic                   device_we_i,
    input  logic [3:0]             device_be_i,
    input  logic [31:0]            device_wdata_i,
    output logic                   device_rvalid_o,
    output logic [31:0]            device_rdata_o,
    output logic                   device_err_o,
    output logic [NumChannels-1:0] pwm_o,
    output logic                   irq_o
);
    logic [NumChannels-1:0] ctrl_q, ctrl_d, ie_q, ie_d, st_q, st_d, w1c, wrap;
    logic [NumChannels-1:0][CtrWidth-1:0] duty_q, duty_d, per_q, per_d;
    logic        rvalid_q, err_q, err_d, hit, wr;
    logic [31:0] rdata_q, rdata_d, rd_word, bemask, wmask;
    logic [4:0]  ch_idx;
    logic        unused_addr;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wm,
                                          input logic [31:0] bm);
        return (old & ~bm) | wm;
    endfunction

    assign unused_addr = ^{device_addr_i[31:12], device_addr_i[1:0]};
    assign wr     = device_req_i & device_we_i;
    assign ch_idx = device_addr_i[7:3];
    assign bemask = {{8{device_be_i[3]}}, {8{device_be_i[2]}},
                     {8{device_be_i[1]}}, {8{device_be_i[0]}}};
    assign wmask  = device_wdata_i & bemask;

    always_comb begin
        ctrl_d  = ctrl_q;
        ie_d    = ie_q;
        duty_d  = duty_q;
        per_d   = per_q;
        w1c     = '0;
        hit     = 1'b0;
        rd_word = '0;
        if (device_addr_i[11:2] == 10'd0) begin
            hit     = 1'b1;
            rd_word = 32'(ctrl_q);
            if (wr) ctrl_d = NumChannels'(merge(32'(ctrl_q), wmask, bemask));
        end else if (device_addr_i[11:2] == 10'd1) begin
            hit     = 1'b1;
            rd_word = 32'(st_q);
            if (wr) w1c = NumChannels'(wmask);
        end else if (device_addr_i[11:2] == 10'd2) begin
            hit     = 1'b1;
            rd_word = 32'(ie_q);
            if (wr) ie_d = NumChannels'(merge(32'(ie_q), wmask, bemask));
        end else if (device_addr_i[11:8] == 4'h1) begin
            // Channels beyond NumChannels never match, so they fall out as errors.
            for (int i = 0; i < NumChannels; i++) begin
                if (ch_idx == 5'(i)) begin
                    hit = 1'b1;
                    if (device_addr_i[2]) begin
                        rd_word = 32'(per_q[i]);
                        if (wr) per_d[i] = CtrWidth'(merge(32'(per_q[i]), wmask, bemask));
                    end else begin
                        rd_word = 32'(duty_q[i]);
                        if (wr) duty_d[i] = CtrWidth'(merge(32'(duty_q[i]), wmask, bemask));
                    end
                end
            end
        end
        // Error accesses must not modify anything.
        if (!hit) begin
            ctrl_d = ctrl_q;
            ie_d   = ie_q;
            duty_d = duty_q;
            per_d  = per_q;
            w1c    = '0;
        end
        st_d    = (st_q & ~w1c) | wrap;
        err_d   = device_req_i & ~hit;
        rdata_d = (device_req_i & ~device_we_i & hit) ? rd_word : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q   <= '0;
            ie_q     <= '0;
            st_q     <= '0;
            duty_q   <= '0;
            per_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            ie_q     <= ie_d;
            st_q     <= st_d;
            duty_q   <= duty_d;
            per_q    <= per_d;
            rvalid_q <= device_req_i;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    for (genvar g = 0; g < NumChannels; g++) begin : g_ch
        pwm_chan #(.CtrWidth(CtrWidth)) u_chan (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .en_i     (ctrl_q[g]),
            .duty_i   (duty_q[g]),
            .period_i (per_q[g]),
            .wrap_o   (wrap[g]),
            .pwm_o    (pwm_o[g])
        );
    end

    assign device_rvalid_o = rvalid_q;
    assign device_rdata_o  = rdata_q;
    assign device_err_o    = err_q;
    assign irq_o           = |(st_q & ie_q);
endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: bus responses go through a scoreboard queue,
// PWM waveforms are checked against a small cycle-indexed model.

module tb_pwm_bank;
    localparam int NCH = 12;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b1;
    logic           req = 1'b0;
    logic [31:0]    addr = '0;
    logic           we = 1'b0;
    logic [3:0]     be = '0;
    logic [31:0]    wdata = '0;
    logic           rvalid, err, irq;
    logic [31:0]    rdata;
    logic [NCH-1:0] pwm;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       tag;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_req = 0;
    int t_en, cw, cwrap;
    logic found;

    pwm_bank #(.NumChannels(NCH), .CtrWidth(8)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .device_req_i    (req),
        .device_addr_i   (addr),
        .device_we_i     (we),
        .device_be_i     (be),
        .device_wdata_i  (wdata),
        .device_rvalid_o (rvalid),
        .device_rdata_o  (rdata),
        .device_err_o    (err),
        .pwm_o           (pwm),
        .irq_o           (irq)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One bus transaction: expectation queued at drive time, popped at rvalid.
    task automatic bus(input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic [31:0] erd, input logic eerr,
                       input string tag);
        exp_t e;
        @(posedge clk_i); #1;
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        last_req = cyc;
        e.rdata = erd; e.err = eerr; e.tag = tag;
        sb.push_back(e);
        @(posedge clk_i); #1;
        req = 1'b0; we = 1'b0;
        @(negedge clk_i);
        chk({tag, " rvalid"}, 32'(rvalid), 32'd1);
        e = sb.pop_front();
        chk({e.tag, " rdata"}, rdata, e.rdata);
        chk({e.tag, " err"}, 32'(err), 32'(e.err));
    endtask

    // Park at a negedge so the next bus request lands on the given ch0 phase.
    task automatic wait_phase(input int ph);
        for (int k = 0; k < 12 && ((cyc + 1 - t_en) % 10 != ph); k++) @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst pwm", 32'(pwm), 32'd0);
        chk("rst irq", 32'(irq), 32'd0);
        chk("rst rvalid", 32'(rvalid), 32'd0);
        chk("rst rdata", rdata, 32'd0);
        chk("rst err", 32'(err), 32'd0);
        bus(1'b0, 32'h000, 4'hF, 0, 32'h0, 1'b0, "rd ctrl0");
        bus(1'b0, 32'h100, 4'hF, 0, 32'h0, 1'b0, "rd duty0");
        @(negedge clk_i);
        chk("idle rvalid", 32'(rvalid), 32'd0);
        chk("idle rdata", rdata, 32'd0);

        // ch0: period 9, duty 3
        bus(1'b1, 32'h104, 4'hF, 32'd9, 32'h0, 1'b0, "wr per0");
        bus(1'b1, 32'h100, 4'hF, 32'd3, 32'h0, 1'b0, "wr duty0");
        bus(1'b1, 32'h000, 4'hF, 32'd1, 32'h0, 1'b0, "wr ctrl");
        t_en = last_req;
        chk("pwm T+1", 32'(pwm[0]), 32'd0);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk_i);
            chk($sformatf("pwm3 k%0d", k), 32'(pwm[0]), 32'((k % 10) < 3));
        end
        bus(1'b0, 32'h004, 4'hF, 0, 32'h1, 1'b0, "st set");

        // Interrupt enable, W1C racing a wrap, W1C in a quiet cycle
        bus(1'b1, 32'h008, 4'hF, 32'd1, 32'h0, 1'b0, "wr ie");
        chk("irq on", 32'(irq), 32'd1);
        wait_phase(0);
        bus(1'b1, 32'h004, 4'hF, 32'd1, 32'h0, 1'b0, "w1c wrap");
        bus(1'b0, 32'h004, 4'hF, 0, 32'h1, 1'b0, "st kept");
        chk("irq kept", 32'(irq), 32'd1);
        wait_phase(3);
        bus(1'b1, 32'h004, 4'hF, 32'd1, 32'h0, 1'b0, "w1c quiet");
        chk("irq drop", 32'(irq), 32'd0);
        bus(1'b0, 32'h004, 4'hF, 0, 32'h0, 1'b0, "st clr");

        // Duty change mid-period applies only after the next wrap
        wait_phase(2);
        bus(1'b1, 32'h100, 4'hF, 32'd7, 32'h0, 1'b0, "wr duty7");
        cw = last_req;
        cwrap = cw + 1;
        while ((cwrap - t_en) % 10 != 0) cwrap++;
        bus(1'b0, 32'h100, 4'hF, 0, 32'd7, 1'b0, "rd duty7");
        for (int k = 0; k < 25; k++) begin
            @(negedge clk_i);
            chk($sformatf("pwm7 c%0d", cyc), 32'(pwm[0]),
                32'(((cyc - t_en - 2) % 10) < ((cyc - 1 > cwrap) ? 7 : 3)));
        end

        // Byte enables and storage width
        bus(1'b1, 32'h114, 4'b0001, 32'hAABBCCDD, 32'h0, 1'b0, "wr per2 be1");
        bus(1'b0, 32'h114, 4'b0000, 0, 32'h000000DD, 1'b0, "rd per2 dd");
        bus(1'b1, 32'h114, 4'b0010, 32'h00000011, 32'h0, 1'b0, "wr per2 be2");
        bus(1'b0, 32'h114, 4'hF, 0, 32'h000000DD, 1'b0, "rd per2 kept");
        bus(1'b1, 32'h000, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b0, "wr ctrl all");
        bus(1'b0, 32'h000, 4'hF, 0, 32'h00000FFF, 1'b0, "rd ctrl mask");
        bus(1'b1, 32'h000, 4'hF, 32'd1, 32'h0, 1'b0, "wr ctrl 1");

        // Error accesses
        bus(1'b0, 32'h160, 4'hF, 0, 32'h0, 1'b1, "rd ch12");
        bus(1'b1, 32'h164, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b1, "wr ch12");
        bus(1'b0, 32'h00C, 4'hF, 0, 32'h0, 1'b1, "rd 00c");
        bus(1'b1, 32'h00C, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b1, "wr 00c");
        bus(1'b0, 32'h15C, 4'hF, 0, 32'h0, 1'b0, "rd per11");
        bus(1'b0, 32'h000, 4'hF, 0, 32'h1, 1'b0, "rd ctrl after err");
        bus(1'b0, 32'h008, 4'hF, 0, 32'h1, 1'b0, "rd ie after err");

        // Reset with pwm high and a read in flight
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk_i);
            found = pwm[0];
        end
        chk("pwm high before rst", 32'(found), 32'd1);
        rst_i = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h100;
        @(posedge clk_i); #1;
        rst_i = 1'b0; req = 1'b0;
        @(negedge clk_i);
        chk("mid rst pwm", 32'(pwm), 32'd0);
        chk("mid rst rvalid", 32'(rvalid), 32'd0);
        chk("mid rst rdata", rdata, 32'd0);
        chk("mid rst irq", 32'(irq), 32'd0);
        bus(1'b0, 32'h000, 4'hF, 0, 32'h0, 1'b0, "post rst ctrl");
        bus(1'b0, 32'h004, 4'hF, 0, 32'h0, 1'b0, "post rst st");
        bus(1'b0, 32'h008, 4'hF, 0, 32'h0, 1'b0, "post rst ie");
        bus(1'b0, 32'h100, 4'hF, 0, 32'h0, 1'b0, "post rst duty0");
        bus(1'b0, 32'h104, 4'hF, 0, 32'h0, 1'b0, "post rst per0");
        bus(1'b0, 32'h114, 4'hF, 0, 32'h0, 1'b0, "post rst per2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
